// File: rtl/fetch_unit_pkg.sv
// fetch_defs: shared widths, the fetch record type and PC alignment helper for the fetch stage.
package fetch_defs;
  localparam int INSTR_W = 32;
  localparam int PC_W = 16;
  localparam int PC_INC = 4;
  typedef logic [PC_W-1:0] pc_t;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    pc_t pc;
  } fetch_t;
  function automatic pc_t align(input pc_t a);
    return {a[PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: 2-entry synchronous FIFO of {instr, pc}; flush beats push, entry 0 is the head.
module fetch_skid
  import fetch_defs::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_t     din,
  output logic [1:0] count,
  output fetch_t     head
);
  fetch_t e1;
  logic [1:0] n;
  assign n = count - 2'(pop);
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      count <= 2'd0;
      head <= '0;
      e1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (pop) head <= e1;
      if (push && n == 2'd0) head <= din;
      if (push && n == 2'd1) e1 <= din;
      count <= n + 2'(push);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/issue logic over a 1-cycle-latency RAM, buffering fetched words in fetch_skid.
module fetch_unit
  import fetch_defs::*;
#(
  parameter logic [15:0] reset_pc = 16'h0000,
  parameter int adr_width = 11
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic [15:0] mem_a,
  output logic        mem_we,
  input  logic [31:0] mem_di,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [15:0] out_pc
);
  if (adr_width < 3 || adr_width > PC_W) begin : g_bad_adr
    $error("adr_width must lie in 3..16");
  end
  pc_t pc, inflight_pc;
  logic inflight, pop, issue;
  logic [1:0] count;
  logic [2:0] occ;
  fetch_t head;
  assign mem_we = 1'b0;
  assign out_valid = count != 2'd0;
  assign pop = out_valid && out_ready;
  // Words owned by the FIFO or in flight after this cycle's pop; keep them within 2 slots.
  assign occ = 3'(count) + 3'(inflight) - 3'(pop);
  assign issue = redirect || occ < 3'd2;
  assign mem_a = redirect ? align(redirect_pc) : pc;
  assign out_instr = head.instr;
  assign out_pc = head.pc;
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      pc <= align(reset_pc);
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else if (issue) begin
      pc <= mem_a + 16'(PC_INC);
      inflight <= 1'b1;
      inflight_pc <= mem_a;
    end else begin
      inflight <= 1'b0;
    end
  end
  fetch_skid u_skid (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .push   (inflight && !redirect),
    .pop    (pop),
    .flush  (redirect),
    .din    ('{instr: mem_di, pc: inflight_pc}),
    .count  (count),
    .head   (head)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table, corner sequences and random traffic checked against an expected-PC stream model.
module tb_fetch_unit;
  localparam logic [15:0] RST_PC = 16'h0000;
  logic sys_clk = 0, sys_rst = 0, redirect = 0, out_ready = 1;
  logic mem_we, out_valid;
  logic [15:0] mem_a, redirect_pc = 0, out_pc;
  logic [31:0] mem_di = 0, out_instr;
  int errors = 0, checks = 0;
  always #5 sys_clk = ~sys_clk;

  fetch_unit #(.reset_pc(RST_PC), .adr_width(11)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mem_a(mem_a), .mem_we(mem_we), .mem_di(mem_di),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  function automatic logic [31:0] word(input logic [15:0] a);
    return 32'h1111_1111 * {23'd0, a[10:2]};
  endfunction

  always @(posedge sys_clk) mem_di <= word(mem_a);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Reference: accepted instructions form a +4 stream from reset_pc or the latest redirect target.
  logic [15:0] exp_pc = RST_PC, hold_pc;
  logic [31:0] hold_instr;
  logic hold = 0;
  int idle = 0;
  always @(negedge sys_clk) begin
    chk("mem_we", {31'd0, mem_we}, 0);
    chk("mem_a_align", {30'd0, mem_a[1:0]}, 0);
    if (!sys_rst) begin
      exp_pc = RST_PC;
      hold = 0;
      idle = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", {31'd0, out_valid}, 1);
        chk("hold_pc", {16'd0, out_pc}, {16'd0, hold_pc});
        chk("hold_instr", out_instr, hold_instr);
      end
      idle = out_valid ? 0 : idle + 1;
      chk("progress", {31'd0, idle > 2}, 0);
      if (out_valid && out_ready) begin
        chk("stream_pc", {16'd0, out_pc}, {16'd0, exp_pc});
        chk("stream_instr", out_instr, word(exp_pc));
        exp_pc = exp_pc + 16'd4;
      end
      hold = out_valid && !out_ready && !redirect;
      hold_pc = out_pc;
      hold_instr = out_instr;
      if (redirect) begin
        exp_pc = {redirect_pc[15:2], 2'b00};
        idle = 0;
      end
    end
  end

  typedef struct {
    logic ready;
    logic redir;
    logic [15:0] rpc;
    logic ev;
    logic [15:0] epc;
  } vec_t;
  vec_t vec[12];

  initial begin
    logic [15:0] hp, ma;
    logic [31:0] hi;
    vec[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vec[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
    vec[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004};
    vec[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008};
    vec[4]  = '{1'b1, 1'b1, 16'h0103, 1'b0, 16'h0000};
    vec[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0100};
    vec[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0104};
    vec[7]  = '{1'b1, 1'b1, 16'hFFF8, 1'b0, 16'h0000};
    vec[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFF8};
    vec[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFC};
    vec[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
    vec[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004};
    repeat (3) step();
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_pc", {16'd0, out_pc}, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_mem_a", {16'd0, mem_a}, {16'd0, RST_PC});
    sys_rst = 1;
    for (int i = 0; i < 12; i++) begin
      out_ready = vec[i].ready;
      redirect = vec[i].redir;
      redirect_pc = vec[i].rpc;
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vec[i].ev});
      if (vec[i].ev) begin
        chk($sformatf("vec%0d_pc", i), {16'd0, out_pc}, {16'd0, vec[i].epc});
        chk($sformatf("vec%0d_instr", i), out_instr, word(vec[i].epc));
      end
    end
    redirect = 0;
    out_ready = 0;
    hp = out_pc;
    hi = out_instr;
    ma = mem_a;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_pc", {16'd0, out_pc}, {16'd0, hp});
      chk("stall_instr", out_instr, hi);
      if (i == 1) ma = mem_a;
      if (i > 1) chk("stall_mem_a", {16'd0, mem_a}, {16'd0, ma});
    end
    out_ready = 1;
    repeat (6) step();
    out_ready = 0;
    repeat (3) step();
    redirect = 1;
    redirect_pc = 16'h0103;
    step();
    redirect = 0;
    chk("full_redir_valid", {31'd0, out_valid}, 0);
    out_ready = 1;
    step();
    chk("full_redir_tvalid", {31'd0, out_valid}, 1);
    chk("full_redir_pc", {16'd0, out_pc}, 32'h0100);
    chk("full_redir_instr", out_instr, 32'h4444_4440);
    repeat (4) step();
    out_ready = 0;
    repeat (3) step();
    sys_rst = 0;
    redirect = 1;
    redirect_pc = 16'h0200;
    step();
    redirect = 0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_pc", {16'd0, out_pc}, 0);
    chk("mid_rst_mem_a", {16'd0, mem_a}, {16'd0, RST_PC});
    sys_rst = 1;
    out_ready = 1;
    step();
    chk("restart_gap", {31'd0, out_valid}, 0);
    step();
    chk("restart_valid", {31'd0, out_valid}, 1);
    chk("restart_pc", {16'd0, out_pc}, {16'd0, RST_PC});
    for (int i = 0; i < 3000; i++) begin
      out_ready = $urandom_range(0, 3) != 0;
      redirect = $urandom_range(0, 19) == 0;
      redirect_pc = 16'($urandom);
      sys_rst = $urandom_range(0, 199) != 0;
      step();
    end
    sys_rst = 1;
    redirect = 0;
    out_ready = 1;
    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
